f_mult_round: RTL and testbench

F_MULT_ROUND -- requirements
Module: F_mult_round

---
 rtl/f_mult_round.sv | 240 ++++++++++++++++++++++++
 tb/tb_f_mult_round.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/f_mult_round.sv
// rtl/f_mult_round.sv - binary32 multiplier back end: normalize, round and pack a raw significand product
//
// Two register stages: S1 normalizes the 48-bit product (including subnormal
// denormalization), S2 rounds, detects overflow, packs and holds the result.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        input handshake
//   in_sign, in_exp, in_mant product sign, biased exponent sum (10-bit two's
//                            complement), raw 24x24 significand product
//   in_class, in_nv, in_rm   operand class, invalid flag, rounding mode
//   out_valid/out_ready      output handshake
//   y, flags                 packed binary32 result, {NV,DZ,OF,UF,NX}
module f_mult_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mant,
    input  logic [1:0]  in_class,
    input  logic        in_nv,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic [4:0]  flags
);

    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_NAN  = 2'b11;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // S1 registers
    logic               s1_valid;
    logic               s1_sign;
    logic [2:0]         s1_rm;
    logic [1:0]         s1_class;
    logic               s1_nv;
    logic [23:0]        s1_sig;
    logic               s1_g;
    logic               s1_s;
    logic signed [10:0] s1_exp;
    logic               s1_tiny;

    // Normalize (combinational, feeds S1)
    logic signed [10:0] n_exp;
    logic signed [10:0] sh_amt;
    logic [23:0]        n_sig;
    logic               n_g;
    logic               n_s;
    logic [49:0]        ext;
    logic [23:0]        d_sig;
    logic               d_g;
    logic               d_s;
    logic signed [10:0] d_exp;
    logic               d_tiny;

    // Round/pack (combinational, feeds S2)
    logic               inc;
    logic [24:0]        sum;
    logic signed [10:0] r_exp;
    logic [22:0]        r_frac;
    logic               inexact;
    logic               ovf;
    logic               ovf_inf;
    logic [31:0]        r_y;
    logic [4:0]         r_flags;

    logic               s2_load;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    always_comb begin
        n_sig  = '0;
        n_g    = 1'b0;
        n_s    = 1'b0;
        n_exp  = '0;
        sh_amt = '0;
        ext    = '0;
        d_sig  = '0;
        d_g    = 1'b0;
        d_s    = 1'b0;
        d_exp  = '0;
        d_tiny = 1'b0;

        // Leading one is at bit 47 or 46; bit 47 means the product is in [2,4).
        if (in_mant[47]) begin
            n_sig = in_mant[47:24];
            n_g   = in_mant[23];
            n_s   = |in_mant[22:0];
            n_exp = $signed({in_exp[9], in_exp}) + 11'sd1;
        end else begin
            n_sig = in_mant[46:23];
            n_g   = in_mant[22];
            n_s   = |in_mant[21:0];
            n_exp = $signed({in_exp[9], in_exp});
        end

        sh_amt = 11'sd1 - n_exp;

        if (n_exp <= 11'sd0) begin
            d_tiny = 1'b1;
            d_exp  = '0;
            if (sh_amt > 11'sd25) begin
                d_sig = '0;
                d_g   = 1'b0;
                d_s   = 1'b1;
            end else begin
                // Shift {sig,guard} into a 25-bit catch area; anything that
                // lands below the guard position is folded into sticky.
                ext   = {n_sig, n_g, 25'b0} >> sh_amt[4:0];
                d_sig = ext[49:26];
                d_g   = ext[25];
                d_s   = n_s | (|ext[24:0]);
            end
        end else begin
            d_sig = n_sig;
            d_g   = n_g;
            d_s   = n_s;
            d_exp = n_exp;
        end
    end

    always_comb begin
        inc     = 1'b0;
        sum     = '0;
        r_exp   = '0;
        r_frac  = '0;
        inexact = 1'b0;
        ovf     = 1'b0;
        ovf_inf = 1'b0;
        r_y     = '0;
        r_flags = '0;

        case (s1_rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = (s1_g | s1_s) & s1_sign;
            RM_RUP:  inc = (s1_g | s1_s) & !s1_sign;
            RM_RMM:  inc = s1_g;
            default: inc = s1_g & (s1_s | s1_sig[0]);
        endcase

        sum = {1'b0, s1_sig} + {24'b0, inc};

        // Carry-out renormalizes to 1.0 x 2^(e+1); a subnormal that rounds up
        // into the hidden-bit position becomes the smallest normal.
        if (sum[24]) begin
            r_exp  = s1_exp + 11'sd1;
            r_frac = '0;
        end else if (s1_exp == 11'sd0 && sum[23]) begin
            r_exp  = 11'sd1;
            r_frac = sum[22:0];
        end else begin
            r_exp  = s1_exp;
            r_frac = sum[22:0];
        end

        inexact = s1_g | s1_s;
        ovf     = r_exp >= 11'sd255;

        case (s1_rm)
            RM_RTZ:  ovf_inf = 1'b0;
            RM_RDN:  ovf_inf = s1_sign;
            RM_RUP:  ovf_inf = !s1_sign;
            default: ovf_inf = 1'b1;
        endcase

        case (s1_class)
            CLS_ZERO: begin
                r_y     = {s1_sign, 31'b0};
                r_flags = {s1_nv, 4'b0};
            end
            CLS_INF: begin
                r_y     = {s1_sign, 8'hFF, 23'b0};
                r_flags = {s1_nv, 4'b0};
            end
            CLS_NAN: begin
                r_y     = 32'h7FC0_0000;
                r_flags = {s1_nv, 4'b0};
            end
            default: begin
                if (ovf) begin
                    r_y     = ovf_inf ? {s1_sign, 8'hFF, 23'b0} : {s1_sign, 8'hFE, 23'h7FFFFF};
                    r_flags = {s1_nv, 1'b0, 1'b1, 1'b0, 1'b1};
                end else begin
                    r_y     = {s1_sign, r_exp[7:0], r_frac};
                    r_flags = {s1_nv, 1'b0, 1'b0, s1_tiny & inexact, inexact};
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_rm     <= '0;
            s1_class  <= '0;
            s1_nv     <= 1'b0;
            s1_sig    <= '0;
            s1_g      <= 1'b0;
            s1_s      <= 1'b0;
            s1_exp    <= '0;
            s1_tiny   <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= '0;
        end else begin
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    y     <= r_y;
                    flags <= r_flags;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign  <= in_sign;
                    s1_rm    <= in_rm;
                    s1_class <= in_class;
                    s1_nv    <= in_nv;
                    s1_sig   <= d_sig;
                    s1_g     <= d_g;
                    s1_s     <= d_s;
                    s1_exp   <= d_exp;
                    s1_tiny  <= d_tiny;
                end
            end
        end
    end

endmodule

// File: tb/tb_f_mult_round.sv
// tb/tb_f_mult_round.sv - scoreboard testbench for f_mult_round
module tb_f_mult_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic [1:0]  in_class;
    logic        in_nv;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic [4:0]  flags;

    typedef struct packed {
        logic [31:0] y;
        logic [4:0]  f;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;
    localparam logic [4:0] F_NX = 5'b00001, F_UF = 5'b00010, F_OF = 5'b00100, F_NV = 5'b10000;

    f_mult_round dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sign  (in_sign),
        .in_exp   (in_exp),
        .in_mant  (in_mant),
        .in_class (in_class),
        .in_nv    (in_nv),
        .in_rm    (in_rm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: a transfer happens on the next posedge when valid && ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual y=%h flags=%h required none", y, flags);
            end else begin
                mon_e = sb.pop_front();
                check("result_y", y, mon_e.y);
                check("result_flags", {27'b0, flags}, {27'b0, mon_e.f});
            end
        end
    end

    task automatic drive(input logic [47:0] m, input logic [9:0] e, input logic [2:0] rm,
                         input logic s, input logic [1:0] cl, input logic nv);
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        in_rm    = rm;
        in_sign  = s;
        in_class = cl;
        in_nv    = nv;
    endtask

    task automatic send(input logic [47:0] m, input logic [9:0] e, input logic [2:0] rm,
                        input logic s, input logic [1:0] cl, input logic nv,
                        input logic [31:0] ey, input logic [4:0] ef);
        bit accepted = 0;
        drive(m, e, rm, s, cl, nv);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({ey, ef});
                accepted = 1;
                break;
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_class  = '0;
        in_nv     = 1'b0;
        in_rm     = '0;
        out_ready = 1'b1;

        #12;
        check("reset_out_valid", {31'b0, out_valid}, 0);
        check("reset_y", y, 0);
        check("reset_flags", {27'b0, flags}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("ready_after_reset", {31'b0, in_ready}, 1);

        // 1.5 x 1.5 with latency check
        send(48'h900000000000, 10'd127, RNE, 1'b0, 2'b00, 1'b0, 32'h40100000, 5'b0);
        check("latency_s1", {31'b0, out_valid}, 0);
        @(posedge clk);
        #1;
        check("latency_s2", {31'b0, out_valid}, 1);
        drain();

        // Back-to-back directed vectors
        send(48'h400000400000, 10'd127, RNE, 1'b0, 2'b00, 1'b0, 32'h3F800000, F_NX);
        send(48'h400000400000, 10'd127, RUP, 1'b0, 2'b00, 1'b0, 32'h3F800001, F_NX);
        send(48'h400000400000, 10'd127, RTZ, 1'b0, 2'b00, 1'b0, 32'h3F800000, F_NX);
        send(48'h400000400000, 10'd127, RMM, 1'b0, 2'b00, 1'b0, 32'h3F800001, F_NX);
        send(48'h400000400000, 10'd127, 3'b101, 1'b0, 2'b00, 1'b0, 32'h3F800000, F_NX);
        send(48'h800000000000, 10'd254, RNE, 1'b0, 2'b00, 1'b0, 32'h7F800000, F_OF | F_NX);
        send(48'h800000000000, 10'd254, RTZ, 1'b0, 2'b00, 1'b0, 32'h7F7FFFFF, F_OF | F_NX);
        send(48'h800000000000, 10'd254, RDN, 1'b0, 2'b00, 1'b0, 32'h7F7FFFFF, F_OF | F_NX);
        send(48'h800000000000, 10'd254, RDN, 1'b1, 2'b00, 1'b0, 32'hFF800000, F_OF | F_NX);
        send(48'h400000000001, 10'h3E2, RNE, 1'b0, 2'b00, 1'b0, 32'h00000000, F_UF | F_NX);
        send(48'h400000000001, 10'd0,   RNE, 1'b0, 2'b00, 1'b0, 32'h00400000, F_UF | F_NX);
        send(48'h7FFFFF800000, 10'd0,   RNE, 1'b0, 2'b00, 1'b0, 32'h00800000, F_UF | F_NX);
        send(48'hFFFFFF800000, 10'd127, RUP, 1'b0, 2'b00, 1'b0, 32'h40800000, F_NX);
        send(48'h0,            10'd0,   RNE, 1'b0, 2'b11, 1'b1, 32'h7FC00000, F_NV);
        send(48'h0,            10'd0,   RNE, 1'b1, 2'b01, 1'b0, 32'h80000000, 5'b0);
        send(48'h0,            10'd0,   RUP, 1'b0, 2'b10, 1'b0, 32'h7F800000, 5'b0);
        drain();

        // Backpressure: third input blocked, head result held stable
        out_ready = 1'b0;
        send(48'h900000000000, 10'd127, RNE, 1'b0, 2'b00, 1'b0, 32'h40100000, 5'b0);
        send(48'h400000400000, 10'd127, RUP, 1'b0, 2'b00, 1'b0, 32'h3F800001, F_NX);
        drive(48'h0, 10'd0, RNE, 1'b0, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'b0, in_ready}, 0);
            check("bp_out_valid", {31'b0, out_valid}, 1);
            check("bp_y_hold", y, 32'h40100000);
            check("bp_flags_hold", {27'b0, flags}, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(48'h0, 10'd0, RNE, 1'b0, 2'b11, 1'b1, 32'h7FC00000, F_NV);
        drain();

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(48'h900000000000, 10'd127, RNE, 1'b0, 2'b00, 1'b0, 32'h40100000, 5'b0);
        send(48'h800000000000, 10'd254, RNE, 1'b0, 2'b00, 1'b0, 32'h7F800000, F_OF | F_NX);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {31'b0, out_valid}, 0);
        check("async_rst_y", y, 0);
        check("async_rst_flags", {27'b0, flags}, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("ready_after_rst_pulse", {31'b0, in_ready}, 1);
        repeat (4) @(posedge clk);
        #1;
        check("no_stale_output", {31'b0, out_valid}, 0);

        // Pipeline still works after the reset pulse
        send(48'h400000400000, 10'd127, RTZ, 1'b0, 2'b00, 1'b0, 32'h3F800000, F_NX);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
